niosii_system_nios2_qsys_0_div_cell: RTL and testbench



---
 rtl/niosii_system_nios2_qsys_0_div_cell_pkg.sv | 8 +
 rtl/niosii_system_nios2_qsys_0_div_step.sv | 25 ++
 rtl/niosii_system_nios2_qsys_0_div_cell.sv | 114 +++++++++++
 tb/tb_niosii_system_nios2_qsys_0_div_cell.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/niosii_system_nios2_qsys_0_div_cell_pkg.sv
// niosii_div_cell_pkg: shared state encoding and constants for the Nios II divide cell
package niosii_div_cell_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} div_state_t;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  // Divide-by-zero quotient is this bit replicated across the result width.
  localparam logic DIV_BY_ZERO_QUOT = 1'b1;
endpackage

// File: rtl/niosii_system_nios2_qsys_0_div_step.sv
// niosii_system_nios2_qsys_0_div_step: one combinational radix-2 restoring divide step
//   rem_in  : partial remainder (WIDTH+1 bits)
//   q_in    : dividend/quotient shift register; its MSB is shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_out   : q_in shifted left with the new quotient bit in the LSB
module niosii_system_nios2_qsys_0_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
    // One spare bit above the shifted remainder carries the trial-subtract sign.
    diff    = {rem_in, q_in[WIDTH-1]} - {2'b00, divisor};
    rem_out = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
    q_out   = {q_in[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/niosii_system_nios2_qsys_0_div_cell.sv
// niosii_system_nios2_qsys_0_div_cell: sequential restoring divider for Nios II div/divu
//   clk, reset (async, active-high)
//   M_div_start/M_div_signed/M_div_src1/M_div_src2 : request, captured in IDLE only
//   M_div_busy      : state != IDLE or done pulse
//   M_div_done      : one-cycle pulse, results held afterwards
//   M_div_quotient/M_div_remainder/M_div_by_zero : results
//   Optional macro DIV_CELL_EARLY_EXIT_EN: skip iteration when |divisor| > |dividend|.
module niosii_system_nios2_qsys_0_div_cell
  import niosii_div_cell_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_div_start,
  input  logic             M_div_signed,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quotient,
  output logic [WIDTH-1:0] M_div_remainder,
  output logic             M_div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic             sgn, neg_q, neg_r, zero, hold;
  logic [WIDTH-1:0] a, b, dvd, dvs, mag_a, mag_b, rem_lo;
  logic [WIDTH:0]   rem, rem_nx;
  logic [WIDTH-1:0] q_nx;
  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned.
  assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign rem_lo = rem[WIDTH-1:0];
  assign M_div_busy = (state != IDLE) || M_div_done;
  niosii_system_nios2_qsys_0_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .q_in    (dvd),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_out   (q_nx)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sgn             <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      zero            <= 1'b0;
      hold            <= 1'b0;
      a               <= '0;
      b               <= '0;
      dvd             <= '0;
      dvs             <= '0;
      rem             <= '0;
      M_div_done      <= 1'b0;
      M_div_quotient  <= '0;
      M_div_remainder <= '0;
      M_div_by_zero   <= 1'b0;
    end else begin
      M_div_done <= 1'b0;
      case (state)
        IDLE: if (M_div_start && !M_div_done) begin
          a     <= M_div_src1;
          b     <= M_div_src2;
          sgn   <= M_div_signed;
          state <= LOAD;
        end
        LOAD: begin
          zero  <= (mag_b == '0);
          neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sgn && a[WIDTH-1];
          dvs   <= mag_b;
          dvd   <= mag_a;
          rem   <= '0;
          hold  <= 1'b0;
          cnt   <= CW'(WIDTH - 1);
          state <= ITER;
          // Short paths spend a single idle ITER cycle so they finish three edges after start.
          if (mag_b == '0) begin
            hold <= 1'b1;
            cnt  <= '0;
          end
`ifdef DIV_CELL_EARLY_EXIT_EN
          else if (mag_b > mag_a) begin
            hold <= 1'b1;
            cnt  <= '0;
            dvd  <= '0;
            rem  <= {1'b0, mag_a};
          end
`endif
        end
        ITER: begin
          if (!hold) begin
            rem <= rem_nx;
            dvd <= q_nx;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          M_div_quotient  <= zero ? {WIDTH{DIV_BY_ZERO_QUOT}} : (neg_q ? -dvd : dvd);
          M_div_remainder <= zero ? a : (neg_r ? -rem_lo : rem_lo);
          M_div_by_zero   <= zero;
          M_div_done      <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_niosii_system_nios2_qsys_0_div_cell.sv
// tb_niosii_system_nios2_qsys_0_div_cell: scoreboard bench with a plain-arithmetic divide model
module tb_niosii_system_nios2_qsys_0_div_cell;
  localparam int W = 32;
  logic          clk = 1'b0, reset = 1'b1, M_div_start = 1'b0, M_div_signed = 1'b0;
  logic [W-1:0]  M_div_src1 = '0, M_div_src2 = '0;
  logic          M_div_busy, M_div_done, M_div_by_zero;
  logic [W-1:0]  M_div_quotient, M_div_remainder;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int          lat;
    int          st;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0, pass = 0, total = 0;
  niosii_system_nios2_qsys_0_div_cell #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .M_div_start     (M_div_start),
    .M_div_signed    (M_div_signed),
    .M_div_src1      (M_div_src1),
    .M_div_src2      (M_div_src2),
    .M_div_busy      (M_div_busy),
    .M_div_done      (M_div_done),
    .M_div_quotient  (M_div_quotient),
    .M_div_remainder (M_div_remainder),
    .M_div_by_zero   (M_div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act === want) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, want);
  endtask
  task automatic chk1(string n, logic act, logic want);
    total++;
    if (act === want) pass++;
    else $display("FAIL %s: got %b expected %b", n, act, want);
  endtask
  // Reference: 64-bit signed arithmetic truncates toward zero and % follows the dividend sign.
  function automatic exp_t model(bit s, logic [31:0] x, logic [31:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    e = '0;
    if (y == 32'd0) begin
      e.q = 32'hFFFFFFFF; e.r = x; e.bz = 1'b1; e.lat = 3;
    end else begin
      sx = s ? {{32{x[31]}}, x} : {32'd0, x};
      sy = s ? {{32{y[31]}}, y} : {32'd0, y};
      q = sx / sy;
      r = sx % sy;
      e.q = q[31:0]; e.r = r[31:0]; e.bz = 1'b0; e.lat = 34;
`ifdef DIV_CELL_EARLY_EXIT_EN
      if ((sy < 0 ? -sy : sy) > (sx < 0 ? -sx : sx)) e.lat = 3;
`endif
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!reset && M_div_done) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", M_div_quotient, mon_e.q);
        chk("remainder", M_div_remainder, mon_e.r);
        chk1("by_zero", M_div_by_zero, mon_e.bz);
        chk("latency", cyc - mon_e.st, mon_e.lat);
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (M_div_busy && n < 100) begin @(negedge clk); n++; end
    if (M_div_busy) begin total++; $display("FAIL idle_timeout: got busy=1 expected 0"); end
  endtask
  task automatic wait_done();
    int n = 0;
    while (!M_div_done && n < 60) begin @(negedge clk); n++; end
    if (!M_div_done) begin total++; $display("FAIL done_timeout: got done=0 expected 1"); end
  endtask
  task automatic issue(bit s, logic [31:0] x, logic [31:0] y);
    exp_t e;
    wait_idle();
    e = model(s, x, y);
    e.st = cyc + 1;
    sb.push_back(e);
    M_div_start = 1'b1; M_div_signed = s; M_div_src1 = x; M_div_src2 = y;
    @(negedge clk);
    M_div_start = 1'b0;
    chk1("busy_after_start", M_div_busy, 1'b1);
  endtask
  task automatic run(bit s, logic [31:0] x, logic [31:0] y);
    issue(s, x, y);
    wait_done();
    @(negedge clk);
    chk1("done_pulse", M_div_done, 1'b0);
    chk1("idle_after_done", M_div_busy, 1'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] x, y;
    bit s;
    repeat (3) @(negedge clk);
    chk1("rst_busy", M_div_busy, 1'b0);
    chk1("rst_done", M_div_done, 1'b0);
    chk("rst_q", M_div_quotient, 32'd0);
    chk("rst_r", M_div_remainder, 32'd0);
    chk1("rst_bz", M_div_by_zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    run(0, 32'd100, 32'd7);
    run(1, 32'hFFFFFF9C, 32'd7);
    run(1, 32'd100, 32'hFFFFFFF9);
    run(0, 32'd5, 32'd0);
    run(1, 32'h80000000, 32'hFFFFFFFF);
    run(0, 32'd3, 32'd10);
    run(1, 32'hFFFFFFFD, 32'd10);
    // Abort mid-operation: outputs clear without waiting for an edge.
    issue(0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("abort_busy", M_div_busy, 1'b0);
    chk1("abort_done", M_div_done, 1'b0);
    chk("abort_q", M_div_quotient, 32'd0);
    chk("abort_r", M_div_remainder, 32'd0);
    chk1("abort_bz", M_div_by_zero, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(0, 32'd9, 32'd3);
    // Starts while busy and on the done cycle must be ignored.
    issue(0, 32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    M_div_start = 1'b1; M_div_src1 = 32'd77; M_div_src2 = 32'd0;
    @(negedge clk);
    M_div_start = 1'b0;
    wait_done();
    M_div_start = 1'b1; M_div_src1 = 32'd55; M_div_src2 = 32'd5;
    @(negedge clk);
    M_div_start = 1'b0;
    chk1("ignored_done_cycle_busy", M_div_busy, 1'b0);
    repeat (40) @(negedge clk);
    chk("hold_q", M_div_quotient, 32'd111);
    chk("hold_r", M_div_remainder, 32'd1);
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = $urandom;
        1: y = $urandom_range(1, 20);
        2: y = -$urandom_range(1, 20);
        3: y = (i % 3 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
        default: y = x >> $urandom_range(0, 8);
      endcase
      if (i % 7 == 0) x = 32'h80000000;
      run(s, x, y);
    end
    if (sb.size() != 0) begin total++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
